// File: rtl/dram_fifo_sync_pkg.sv
// Shared definitions for the synchronous distributed-RAM FIFO and its memory.
//   clogb2     : ceil(log2(value)), used to size pointers and the occupancy count
//   FWFT_TRUE  : FWFT_MODE value selecting first-word-fall-through read
//   FWFT_FALSE : FWFT_MODE value selecting registered (latency 1) read
package dram_fifo_sync_pkg;

  localparam string FWFT_TRUE  = "true";
  localparam string FWFT_FALSE = "false";

  // Number of address bits needed to index 'value' entries (value >= 2).
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dram_sdp_sync.sv
// Simple dual-port distributed RAM: synchronous write port, asynchronous read.
// Contents are not reset.
//   clk     : write clock
//   i_wen   : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, combinational from i_raddr
module dram_sdp_sync
  import dram_fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 32
) (
  input  logic                        clk,
  input  logic                        i_wen,
  input  logic [clogb2(DEPTH)-1:0]    i_waddr,
  input  logic [DATA_WIDTH-1:0]       i_wdata,
  input  logic [clogb2(DEPTH)-1:0]    i_raddr,
  output logic [DATA_WIDTH-1:0]       o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dram_fifo_sync.sv
// Synchronous FIFO built on a distributed-RAM simple dual-port memory.
// Full/empty are decided from registered state only, so a same-cycle read
// never frees a slot for a write at full and a same-cycle write never
// supplies data for a read at empty.
//   clk, rst                          : clock, async active-high reset
//   fifo_wen, fifo_din                : write request and data
//   fifo_ren, fifo_dout               : read/pop request and data
//   fifo_full, fifo_almost_full       : occupancy == DEPTH / >= ALMOST_FULL_TH
//   fifo_empty, fifo_almost_empty     : occupancy == 0 / <= ALMOST_EMPTY_TH
//   data_cnt                          : current occupancy
//   overflow, underflow               : one-cycle pulse after a rejected write/read
module dram_fifo_sync
  import dram_fifo_sync_pkg::*;
#(
  parameter int    DATA_WIDTH      = 24,
  parameter int    DEPTH           = 32,
  parameter string FWFT_MODE       = FWFT_FALSE,
  parameter int    ALMOST_FULL_TH  = DEPTH - 2,
  parameter int    ALMOST_EMPTY_TH = 2,
  parameter int    SIM_DELAY       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_wen,
  input  logic [DATA_WIDTH-1:0]     fifo_din,
  output logic                      fifo_full,
  output logic                      fifo_almost_full,
  input  logic                      fifo_ren,
  output logic [DATA_WIDTH-1:0]     fifo_dout,
  output logic                      fifo_empty,
  output logic                      fifo_almost_empty,
  output logic [clogb2(DEPTH):0]    data_cnt,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW   = clogb2(DEPTH);
  localparam int CW   = AW + 1;
  localparam bit FWFT = (FWFT_MODE == FWFT_TRUE);

  // SIM_DELAY only models register update delay in simulation; synthesized
  // logic has no delay, so it is only range-checked here.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || SIM_DELAY < 0 ||
      (FWFT_MODE != FWFT_TRUE && FWFT_MODE != FWFT_FALSE)) begin : g_param_err
    $error("dram_fifo_sync: illegal parameter value");
  end

  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_full, r_afull, r_empty, r_aempty, r_ovf, r_udf;
  logic                  w_wr_acc, w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_wr_acc = fifo_wen & ~r_full;
  assign w_rd_acc = fifo_ren & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Flags are registered from the next count so they line up with data_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt    <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == CW'(DEPTH));
      r_afull  <= (w_cnt_nxt >= CW'(ALMOST_FULL_TH));
      r_empty  <= (w_cnt_nxt == '0);
      r_aempty <= (w_cnt_nxt <= CW'(ALMOST_EMPTY_TH));
      r_ovf    <= fifo_wen & r_full;
      r_udf    <= fifo_ren & r_empty;
    end
  end

  dram_sdp_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_wen   (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (fifo_din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  if (FWFT) begin : g_fwft
    // Head word is always visible; a pop advances the read pointer.
    assign fifo_dout = w_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_dout;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_dout <= '0;
      else if (w_rd_acc) r_dout <= w_rdata;
    end
    assign fifo_dout = r_dout;
  end

  assign fifo_full         = r_full;
  assign fifo_almost_full  = r_afull;
  assign fifo_empty        = r_empty;
  assign fifo_almost_empty = r_aempty;
  assign data_cnt          = r_cnt;
  assign overflow          = r_ovf;
  assign underflow         = r_udf;

endmodule

// File: tb/tb_dram_fifo_sync.sv
// Bench for dram_fifo_sync: one standard-read and one FWFT instance driven by
// the same stimulus, compared each cycle against a queue-based model, plus
// literal expectations for the directed scenarios.
module tb_dram_fifo_sync;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_wen = 1'b0;
  logic          fifo_ren = 1'b0;
  logic [DW-1:0] fifo_din = '0;

  logic          full_s, afull_s, empty_s, aempty_s, ovf_s, udf_s;
  logic [DW-1:0] dout_s;
  logic [4:0]    cnt_s;
  logic          full_f, afull_f, empty_f, aempty_f, ovf_f, udf_f;
  logic [DW-1:0] dout_f;
  logic [4:0]    cnt_f;

  always #5 clk = ~clk;

  dram_fifo_sync #(
    .DATA_WIDTH(DW), .DEPTH(DP), .FWFT_MODE("false"),
    .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE), .SIM_DELAY(1)
  ) u_std (
    .clk(clk), .rst(rst), .fifo_wen(fifo_wen), .fifo_din(fifo_din),
    .fifo_full(full_s), .fifo_almost_full(afull_s), .fifo_ren(fifo_ren),
    .fifo_dout(dout_s), .fifo_empty(empty_s), .fifo_almost_empty(aempty_s),
    .data_cnt(cnt_s), .overflow(ovf_s), .underflow(udf_s)
  );

  dram_fifo_sync #(
    .DATA_WIDTH(DW), .DEPTH(DP), .FWFT_MODE("true"),
    .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE), .SIM_DELAY(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .fifo_wen(fifo_wen), .fifo_din(fifo_din),
    .fifo_full(full_f), .fifo_almost_full(afull_f), .fifo_ren(fifo_ren),
    .fifo_dout(dout_f), .fifo_empty(empty_f), .fifo_almost_empty(aempty_f),
    .data_cnt(cnt_f), .overflow(ovf_f), .underflow(udf_f)
  );

  // Behavioural model
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf, m_udf;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r);
    bit was_full, was_empty;
    was_full  = (q.size() == DP);
    was_empty = (q.size() == 0);
    m_ovf = w && was_full;
    m_udf = r && was_empty;
    if (r && !was_empty) m_dout = q.pop_front();
    if (w && !was_full)  q.push_back(d);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("cnt_s",    32'(cnt_s),    32'(n));
    chk("full_s",   32'(full_s),   32'(n == DP));
    chk("afull_s",  32'(afull_s),  32'(n >= AF));
    chk("empty_s",  32'(empty_s),  32'(n == 0));
    chk("aempty_s", 32'(aempty_s), 32'(n <= AE));
    chk("ovf_s",    32'(ovf_s),    32'(m_ovf));
    chk("udf_s",    32'(udf_s),    32'(m_udf));
    chk("dout_s",   32'(dout_s),   32'(m_dout));
    chk("cnt_f",    32'(cnt_f),    32'(n));
    chk("full_f",   32'(full_f),   32'(n == DP));
    chk("afull_f",  32'(afull_f),  32'(n >= AF));
    chk("empty_f",  32'(empty_f),  32'(n == 0));
    chk("aempty_f", 32'(aempty_f), 32'(n <= AE));
    chk("ovf_f",    32'(ovf_f),    32'(m_ovf));
    chk("udf_f",    32'(udf_f),    32'(m_udf));
    if (n > 0) chk("dout_f", 32'(dout_f), 32'(q[0]));
  endtask

  // Drive one cycle: inputs held across the rising edge, checked on the falling one.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    fifo_wen = w;
    fifo_din = d;
    fifo_ren = r;
    @(posedge clk);
    model_edge(w, d, r);
    @(negedge clk);
    fifo_wen = 1'b0;
    fifo_ren = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_cnt", 32'(cnt_s), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    chk("rst_empty", 32'(empty_s), 32'd1);
    chk("rst_dout",  32'(dout_s),  32'd0);
    rst = 1'b0;

    // Fill 0x01..0x10, then one rejected write
    for (int i = 1; i <= DP; i++) begin
      step(1'b1, DW'(i), 1'b0);
      chk("fill_cnt", 32'(cnt_s), 32'(i));
      chk("fill_af",  32'(afull_s), 32'(i >= AF));
    end
    chk("fill_full", 32'(full_s), 32'd1);
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_pulse", 32'(ovf_s), 32'd1);
    chk("ovf_cnt",   32'(cnt_s), 32'd16);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", 32'(ovf_s), 32'd0);

    // Drain in order, then one rejected read
    for (int i = 1; i <= DP; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_std", 32'(dout_s), 32'(i));
    end
    chk("drain_empty", 32'(empty_s), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_pulse", 32'(udf_s), 32'd1);
    chk("udf_dout",  32'(dout_s), 32'h10);

    // FWFT: word visible before any read
    step(1'b1, 8'hA5, 1'b0);
    chk("fwft_empty", 32'(empty_f), 32'd0);
    chk("fwft_dout",  32'(dout_f),  32'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk("fwft_pop",   32'(empty_f), 32'd1);
    chk("std_a5",     32'(dout_s),  32'hA5);

    // Steady state at occupancy 8 with simultaneous read/write
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'($urandom), 1'b1);
      chk("steady_cnt", 32'(cnt_s), 32'd8);
    end

    // Simultaneous read/write at full
    while (q.size() < DP) step(1'b1, DW'($urandom), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    chk("full_rw_ovf", 32'(ovf_s), 32'd1);
    chk("full_rw_cnt", 32'(cnt_s), 32'd15);

    // Async reset mid-stream at occupancy 9
    while (q.size() > 9) step(1'b0, 8'h00, 1'b1);
    chk("pre_rst_cnt", 32'(cnt_s), 32'd9);
    do_reset();
    step(1'b1, 8'h3C, 1'b0);
    chk("post_rst_fwft", 32'(dout_f), 32'h3C);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_std", 32'(dout_s), 32'h3C);

    // Random traffic in phases biased towards filling and draining
    for (int ph = 0; ph < 12; ph++) begin
      int wb, rb;
      wb = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      rb = 100 - wb;
      for (int i = 0; i < 120; i++) begin
        step(($urandom_range(0, 99) < wb), DW'($urandom),
             ($urandom_range(0, 99) < rb));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dram_fifo_sync.md
DRAM_FIFO_SYNC -- requirements
Module: dram_fifo_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, giving the bit width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 32, giving the word count; it is a power of 2 and at least 4.
REQ-003 SHALL have parameter FWFT_MODE, default "false": "true" selects first-word-fall-through, "false" selects standard read.
REQ-004 SHALL have parameter ALMOST_FULL_TH, default DEPTH-2, the count at or above which almost-full asserts.
REQ-005 SHALL have parameter ALMOST_EMPTY_TH, default 2, the count at or below which almost-empty asserts.
REQ-006 SHALL have parameter SIM_DELAY, default 1, a simulation-only register update delay in ns.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port fifo_wen, input, 1 bit: write request.
REQ-010 SHALL have port fifo_din, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port fifo_full, output, 1 bit: FIFO holds DEPTH words.
REQ-012 SHALL have port fifo_almost_full, output, 1 bit: data_cnt >= ALMOST_FULL_TH.
REQ-013 SHALL have port fifo_ren, input, 1 bit: read or pop request.
REQ-014 SHALL have port fifo_dout, output, DATA_WIDTH bits: read data.
REQ-015 SHALL have port fifo_empty, output, 1 bit: FIFO holds 0 words.
REQ-016 SHALL have port fifo_almost_empty, output, 1 bit: data_cnt <= ALMOST_EMPTY_TH.
REQ-017 SHALL have port data_cnt, output, log2(DEPTH)+1 bits: current occupancy.
REQ-018 SHALL have port overflow, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-019 SHALL have port underflow, output, 1 bit: one-cycle pulse when a read is rejected.

Function
REQ-020 SHALL accept a write when fifo_wen=1 and fifo_full=0, store fifo_din at the write pointer, then increment the write pointer modulo DEPTH.
REQ-021 SHALL accept a read when fifo_ren=1 and fifo_empty=0, then increment the read pointer modulo DEPTH.
REQ-022 SHALL decide full and empty from the registered state only, so a read in the same cycle does not permit a write at full, and a write in the same cycle does not permit a read at empty.
REQ-023 SHALL, on a rejected write or read, leave the pointers, count and memory unchanged and pulse overflow or underflow high for exactly the next cycle.
REQ-024 SHALL update data_cnt each cycle: +1 for an accepted write only, -1 for an accepted read only, unchanged when both or neither are accepted.
REQ-025 SHALL register all flags and have them reflect data_cnt after the same clock edge that updates it; an accepted write into an empty FIFO deasserts fifo_empty one cycle later.
REQ-026 SHALL, with FWFT_MODE="false", register fifo_dout with the word at the read pointer on the edge that accepts the read (read latency 1) and hold it otherwise.
REQ-027 SHALL, with FWFT_MODE="true", drive fifo_dout combinationally with the word at the read pointer (valid whenever fifo_empty=0); a read pops that word and the next word appears after the edge.
REQ-028 SHALL wrap both pointers from DEPTH-1 to 0 without any gap or loss of data.
REQ-029 SHALL treat a write and a read to the same address in one cycle as impossible, because the full/empty rule in REQ-022 excludes it.

Reset
REQ-030 SHALL, while rst=1, immediately clear the pointers and data_cnt, set fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0, overflow=0, underflow=0, and fifo_dout=0 in standard mode.
REQ-031 SHALL not clear memory contents on reset; an assertion of rst during a transfer discards all stored words.

Structure
REQ-032 SHALL place the clogb2 width function and the FWFT_MODE string constants in the shared package used by the memory blocks.
REQ-033 SHALL instantiate one sub-module, dram_sdp_sync: a distributed-RAM simple dual-port memory with a synchronous write port and an asynchronous read port.
REQ-034 SHALL keep all pointer, count and flag logic in dram_fifo_sync.

Verification (DATA_WIDTH=8, DEPTH=16, thresholds 14/2)
REQ-035 SHALL cover reset then a write of 0x01..0x10: fifo_full=1 after the 16th edge, fifo_almost_full=1 once data_cnt reaches 14, and a 17th write produces overflow=1 for one cycle with data_cnt staying 16.
REQ-036 SHALL cover standard mode, reading 16 words: fifo_dout presents 0x01..0x10 in order one cycle after each read, fifo_empty=1 after the last read, and a 17th read produces underflow=1.
REQ-037 SHALL cover FWFT mode, writing 0xA5 into the empty FIFO: fifo_empty falls one cycle later with fifo_dout=0xA5 before any read; a read then gives fifo_empty=1.
REQ-038 SHALL cover simultaneous write and read at occupancy 8 for 40 cycles: data_cnt stays 8, both pointers wrap, and the data order is preserved.
REQ-039 SHALL cover simultaneous write and read when full: the read is accepted, the write is rejected with overflow=1, and data_cnt=15.
REQ-040 SHALL cover rst pulsed mid-stream at data_cnt=9: all outputs take their reset values asynchronously, and a subsequent write of 0x3C is read back first.
